// File: rtl/flat_io_pkg.sv
// Shared types, default widths and result packing for the flat-IO harness.
// No timing or flow control of its own; consumed by the harness, FIFO and interface.
package flat_io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } harness_state_e;

  localparam int IN_W_DEF  = 4;
  localparam int OUT_W_DEF = 3;

  // Stimulus lands above the response; callers truncate to IN_W+OUT_W.
  function automatic logic [63:0] pack_result(input logic [31:0] stim,
                                              input logic [31:0] resp,
                                              input int          resp_w);
    return ({32'd0, stim} << resp_w) | {32'd0, resp};
  endfunction

endpackage

// File: rtl/flat_io_if.sv
// Stimulus and result valid/ready streams of the flat-IO harness.
// Pure wiring: no latency; each stream carries its own ready backpressure.
interface flat_io_if
  import flat_io_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic                  s_valid;
  logic                  s_ready;
  logic [IN_W-1:0]       s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [IN_W+OUT_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/flat_io_fifo.sv
// Show-ahead FIFO: a push is visible on pop_dat the cycle after it is written.
// Push is refused while registered occupancy is full, even if a pop happens that cycle.
module flat_io_fifo
  import flat_io_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/flat_io_harness.sv
// Drives a combinational flat-IO wrapper, holds each vector SETTLE cycles, queues {stim,resp}.
// Accept-to-push is SETTLE cycles; a full FIFO stalls the stage in HOLD, dropping s_ready.
module flat_io_harness
  import flat_io_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  flat_io_if.slave               io,
  output logic [IN_W-1:0]        dut_in,
  input  logic [OUT_W-1:0]       dut_out,
  output logic                   busy,
  output logic [15:0]            txn_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam int RW = IN_W + OUT_W;

  harness_state_e state;
  harness_state_e state_nxt;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [RW-1:0]  push_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    push       = 1'b0;
    io.s_ready = 1'b0;
    case (state)
      IDLE: begin
        io.s_ready = 1'b1;
        if (io.s_valid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Settle done: wait here for FIFO room, keeping dut_in steady.
        if (cnt == '0 && !fifo_full) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in    <= '0;
      cnt       <= '0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        dut_in <= io.s_data;
        cnt    <= CW'(SETTLE - 1);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (push) begin
        txn_count <= txn_count + 16'd1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign push_dat = RW'(pack_result(32'(dut_in), 32'(dut_out), OUT_W));

  flat_io_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (io.m_ready),
    .pop_dat  (io.m_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign io.m_valid = !fifo_empty;

endmodule

// File: tb/tb_flat_io_harness.sv
// Bench for flat_io_harness driving a 2-bit adder wrapper (a=in[3:2], b=in[1:0]).
module tb_flat_io_harness;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  flat_io_if #(.IN_W(4), .OUT_W(3)) bus ();
  logic [3:0]  dut_in;
  logic [2:0]  dut_out;
  logic        busy;
  logic [15:0] txn_count;
  logic [2:0]  fifo_level;

  flat_io_harness #(.IN_W(4), .OUT_W(3), .SETTLE(1), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .io(bus), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .txn_count(txn_count), .fifo_level(fifo_level)
  );
  assign dut_out = {1'b0, dut_in[3:2]} + {1'b0, dut_in[1:0]};

  // SETTLE=3 instance
  flat_io_if #(.IN_W(4), .OUT_W(3)) bus3 ();
  logic [3:0]  dut_in3;
  logic [2:0]  dut_out3;
  logic        busy3;
  logic [15:0] txn_count3;
  logic [2:0]  fifo_level3;

  flat_io_harness #(.IN_W(4), .OUT_W(3), .SETTLE(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .io(bus3), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .txn_count(txn_count3), .fifo_level(fifo_level3)
  );
  assign dut_out3 = {1'b0, dut_in3[3:2]} + {1'b0, dut_in3[1:0]};

  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  bit         rand_ready = 1'b0;
  logic [6:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result: stimulus in the top bits, adder sum below.
  function automatic logic [6:0] model(input logic [3:0] v);
    int a, b, sum;
    a   = int'(v) / 4;
    b   = int'(v) % 4;
    sum = a + b;
    return 7'(int'(v) * 8 + sum);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [3:0] v);
    int budget;
    budget = 200;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    while (!bus.s_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!bus.s_ready) check("send_timeout", 32'(bus.s_ready), 1);
    else exp_q.push_back(model(v));
    tick();
    bus.s_valid = 1'b0;
    bus.s_data  = 4'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 500;
    rand_ready  = 1'b0;
    bus.m_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.m_valid) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_level", 32'(fifo_level), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    pops = 0;
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard: every pop must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(bus.m_data), 32'hFFFF_FFFF);
      end else begin
        check("pop_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
      pops++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v5;

    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus3.s_valid = 1'b0; bus3.s_data = '0; bus3.m_ready = 1'b1;

    // Reset state
    tick();
    check("rst_s_ready", 32'(bus.s_ready), 1);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data", 32'(bus.m_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_s_ready", 32'(bus.s_ready), 1);
    check("idle_dut_in", 32'(dut_in), 0);
    check("idle_txn", 32'(txn_count), 0);
    check("idle_level", 32'(fifo_level), 0);

    // SETTLE=1 single adder vector
    bus.m_ready = 1'b1;
    send(4'b1011);
    check("s1_dut_in", 32'(dut_in), 32'hB);
    check("s1_busy", 32'(busy), 1);
    check("s1_s_ready_hold", 32'(bus.s_ready), 0);
    check("s1_m_valid_early", 32'(bus.m_valid), 0);
    tick();
    check("s1_m_valid", 32'(bus.m_valid), 1);
    check("s1_m_data", 32'(bus.m_data), 32'h5D);
    check("s1_txn", 32'(txn_count), 1);
    check("s1_busy_done", 32'(busy), 0);
    tick();
    check("s1_drained", 32'(bus.m_valid), 0);

    // SETTLE=3: vector held three cycles
    bus3.s_valid = 1'b1;
    bus3.s_data  = 4'hF;
    tick();
    bus3.s_valid = 1'b0;
    bus3.s_data  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      check("s3_busy", 32'(busy3), 1);
      check("s3_dut_in", 32'(dut_in3), 32'hF);
      check("s3_m_valid_early", 32'(bus3.m_valid), 0);
      tick();
    end
    check("s3_busy_done", 32'(busy3), 0);
    check("s3_m_valid", 32'(bus3.m_valid), 1);
    check("s3_m_data", 32'(bus3.m_data), 32'h7E);
    check("s3_txn", 32'(txn_count3), 1);

    // Fill FIFO with m_ready low, stall the 5th vector
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'($urandom));
    tick();
    check("fill_level", 32'(fifo_level), 4);
    v5 = 4'($urandom);
    send(v5);
    tick();
    tick();
    check("stall_busy", 32'(busy), 1);
    check("stall_s_ready", 32'(bus.s_ready), 0);
    check("stall_level", 32'(fifo_level), 4);
    check("stall_dut_in", 32'(dut_in), 32'(v5));
    check("stall_txn", 32'(txn_count), 4);

    // Pop while full with a pending push: push waits one cycle
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("fullpop_level", 32'(fifo_level), 3);
    check("fullpop_busy", 32'(busy), 1);
    check("fullpop_txn", 32'(txn_count), 4);
    tick();
    check("latepush_level", 32'(fifo_level), 4);
    check("latepush_busy", 32'(busy), 0);
    check("latepush_txn", 32'(txn_count), 5);

    send(4'($urandom));
    check("sixth_stall", 32'(busy), 1);
    drain();
    check("six_txn", 32'(txn_count), 6);
    check("six_pops", 32'(pops), 6);

    // Random stream with random result backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) send(4'($urandom));
    drain();
    check("rand_txn", 32'(txn_count), 30);
    check("rand_pops", 32'(pops), 30);

    // Asynchronous reset in HOLD with two queued results
    do_reset();
    bus.m_ready = 1'b0;
    send(4'($urandom));
    send(4'($urandom));
    tick();
    check("pre_rst_level", 32'(fifo_level), 2);
    send(4'($urandom));
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    pops = 0;
    check("arst_s_ready", 32'(bus.s_ready), 1);
    check("arst_m_valid", 32'(bus.m_valid), 0);
    check("arst_m_data", 32'(bus.m_data), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_txn", 32'(txn_count), 0);
    check("arst_dut_in", 32'(dut_in), 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.m_ready = 1'b1;
    send(4'($urandom));
    drain();
    check("post_rst_txn", 32'(txn_count), 1);
    check("post_rst_pops", 32'(pops), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
